axil_mport_reg_bank: RTL and testbench

Parametrised multi-port AXI4-Lite register bank. It is the successor to the fixed two-slave, four-register PCIe register space. NUM_PORTS AXI4-Lite slave ports share one register file of NUM_REGS 32-bit words, with round-robin arbitration, byte strobes, a read-only ID word and a doorbell/interrupt mechanism. It sits between the PCIe/PS-side masters and the platform, as a mailbox and control space.

---
 rtl/axil_mport_reg_bank_if.sv | 50 +++++
 rtl/axil_mport_reg_bank.sv | 164 ++++++++++++++++
 tb/tb_axil_mport_reg_bank.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_mport_reg_bank_if.sv
// AXI4-Lite bundle for all slave ports of the shared register bank.
// Lane p of every vector belongs to port p.
interface axil_mport_reg_bank_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 12
);
  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [NUM_PORTS*3-1:0]          s_axi_awprot;
  logic [NUM_PORTS-1:0]            s_axi_awvalid;
  logic [NUM_PORTS-1:0]            s_axi_awready;
  logic [NUM_PORTS*32-1:0]         s_axi_wdata;
  logic [NUM_PORTS*4-1:0]          s_axi_wstrb;
  logic [NUM_PORTS-1:0]            s_axi_wvalid;
  logic [NUM_PORTS-1:0]            s_axi_wready;
  logic [NUM_PORTS*2-1:0]          s_axi_bresp;
  logic [NUM_PORTS-1:0]            s_axi_bvalid;
  logic [NUM_PORTS-1:0]            s_axi_bready;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_axi_araddr;
  logic [NUM_PORTS*3-1:0]          s_axi_arprot;
  logic [NUM_PORTS-1:0]            s_axi_arvalid;
  logic [NUM_PORTS-1:0]            s_axi_arready;
  logic [NUM_PORTS*32-1:0]         s_axi_rdata;
  logic [NUM_PORTS*2-1:0]          s_axi_rresp;
  logic [NUM_PORTS-1:0]            s_axi_rvalid;
  logic [NUM_PORTS-1:0]            s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    input  s_axi_rready,
    output s_axi_awready, s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    output s_axi_rready,
    input  s_axi_awready, s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axil_mport_reg_bank.sv
// Multi-port AXI4-Lite register bank: shared register file, round-robin
// grant of one access per cycle, ID word and doorbell interrupts.
module axil_mport_reg_bank #(
  parameter int          NUM_PORTS  = 2,
  parameter int          NUM_REGS   = 16,
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] ID_VALUE   = 32'h0002_0000
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  axil_mport_reg_bank_if.slave bus,
  output logic [NUM_PORTS-1:0] irq
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam int RW = $clog2(NUM_REGS);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IW:0]   NR_X = (IW+1)'(NUM_REGS);
  localparam logic [IW-1:0] DBC  = IW'(NUM_REGS - 2);
  localparam logic [IW-1:0] DBS  = IW'(NUM_REGS - 1);
  localparam logic [1:0]    OKAY = 2'b00;
  localparam logic [1:0]    SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WRESP, RRESP} st_t;

  st_t st_q [NUM_PORTS];
  st_t st_d [NUM_PORTS];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic [31:0] db_q, db_d;
  logic [NUM_PORTS-1:0][1:0]  bresp_q, bresp_d;
  logic [NUM_PORTS-1:0][1:0]  rresp_q, rresp_d;
  logic [NUM_PORTS-1:0][31:0] rdata_q, rdata_d;

  logic [NUM_PORTS-1:0] wreq, rreq;
  logic [NUM_PORTS-1:0] awrdy, arrdy;
  logic [NUM_PORTS-1:0] bv, rv;
  logic gnt;
  int gp, cand;
  logic [IW-1:0] idx;
  logic oob;
  logic [31:0] wd, wm;
  logic unused_prot;

  assign unused_prot = ^{bus.s_axi_awprot, bus.s_axi_arprot};

  assign wreq = bus.s_axi_awvalid & bus.s_axi_wvalid;
  assign rreq = bus.s_axi_arvalid;

  // Pick the first idle requester at or above the pointer, wrapping.
  always_comb begin
    gnt  = 1'b0;
    gp   = 0;
    cand = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = (int'(ptr_q) + k) % NUM_PORTS;
      if (!gnt && st_q[cand] == IDLE &&
          (wreq[cand] || rreq[cand])) begin
        gnt = 1'b1;
        gp  = cand;
      end
    end
    if (ARESET) gnt = 1'b0;
  end

  // Port FSMs, register-file update and response capture.
  always_comb begin
    st_d    = st_q;
    ptr_d   = ptr_q;
    regs_d  = regs_q;
    db_d    = db_q;
    bresp_d = bresp_q;
    rresp_d = rresp_q;
    rdata_d = rdata_q;
    awrdy   = '0;
    arrdy   = '0;
    idx     = '0;
    oob     = 1'b0;
    wd      = '0;
    wm      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      case (st_q[p])
        WRESP: if (bus.s_axi_bready[p]) st_d[p] = IDLE;
        RRESP: if (bus.s_axi_rready[p]) st_d[p] = IDLE;
        default: ;
      endcase
    end
    if (gnt) begin
      ptr_d = PW'((gp + 1) % NUM_PORTS);
      if (wreq[gp]) begin
        awrdy[gp] = 1'b1;
        st_d[gp]  = WRESP;
        idx = bus.s_axi_awaddr[gp*ADDR_WIDTH+2 +: IW];
        wd  = bus.s_axi_wdata[gp*32 +: 32];
        for (int b = 0; b < 4; b++)
          wm[8*b +: 8] = {8{bus.s_axi_wstrb[gp*4+b]}};
        oob = ({1'b0, idx} >= NR_X);
        bresp_d[gp] = oob ? SLVERR : OKAY;
        if (!oob) begin
          if (idx == DBC)
            db_d = db_q & ~(wd & wm);
          else if (idx == DBS)
            db_d = db_q | (wd & wm);
          else if (idx != '0)
            regs_d[idx[RW-1:0]] =
              (regs_q[idx[RW-1:0]] & ~wm) | (wd & wm);
        end
      end else begin
        arrdy[gp] = 1'b1;
        st_d[gp]  = RRESP;
        idx = bus.s_axi_araddr[gp*ADDR_WIDTH+2 +: IW];
        oob = ({1'b0, idx} >= NR_X);
        rresp_d[gp] = oob ? SLVERR : OKAY;
        if (oob)             rdata_d[gp] = '0;
        else if (idx == '0)  rdata_d[gp] = ID_VALUE;
        else if (idx == DBC) rdata_d[gp] = '0;
        else if (idx == DBS) rdata_d[gp] = db_q;
        else rdata_d[gp] = regs_q[idx[RW-1:0]];
      end
    end
  end

  // Response valids follow the port state.
  always_comb begin
    bv = '0;
    rv = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bv[p] = (st_q[p] == WRESP);
      rv[p] = (st_q[p] == RRESP);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int p = 0; p < NUM_PORTS; p++) st_q[p] <= IDLE;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      ptr_q   <= '0;
      db_q    <= '0;
      bresp_q <= '0;
      rresp_q <= '0;
      rdata_q <= '0;
    end else begin
      st_q    <= st_d;
      regs_q  <= regs_d;
      ptr_q   <= ptr_d;
      db_q    <= db_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.s_axi_awready = awrdy;
  assign bus.s_axi_wready  = awrdy;
  assign bus.s_axi_arready = arrdy;
  assign bus.s_axi_bvalid  = bv;
  assign bus.s_axi_rvalid  = rv;
  assign bus.s_axi_bresp   = bresp_q;
  assign bus.s_axi_rresp   = rresp_q;
  assign bus.s_axi_rdata   = rdata_q;
  assign irq = db_q[NUM_PORTS-1:0];

endmodule

// File: tb/tb_axil_mport_reg_bank.sv
// Directed bench for axil_mport_reg_bank: vector table plus
// hand-written arbitration and reset corner cases.
module tb_axil_mport_reg_bank;
  localparam int NP = 2;
  localparam int AW = 12;
  localparam logic [31:0] ID = 32'h0002_0000;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [NP-1:0] irq;
  int checks = 0;
  int failures = 0;

  axil_mport_reg_bank_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) bus ();

  axil_mport_reg_bank #(
    .NUM_PORTS(NP), .NUM_REGS(16), .ADDR_WIDTH(AW), .ID_VALUE(ID)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    int          port;
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
    bit          chk_irq;
    logic [1:0]  exp_irq;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t W(int p, logic [11:0] a, logic [31:0] d,
                             logic [3:0] s, logic [1:0] r,
                             bit ci, logic [1:0] ei);
    return '{p, 1'b1, a, d, s, 32'h0, r, ci, ei};
  endfunction

  function automatic vec_t R(int p, logic [11:0] a, logic [31:0] e,
                             logic [1:0] r, bit ci, logic [1:0] ei);
    return '{p, 1'b0, a, 32'h0, 4'h0, e, r, ci, ei};
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
  endtask

  task automatic txn(input int p, input bit wr, input logic [11:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [1:0] resp, output logic [31:0] rd,
                     output logic [1:0] irq_s, output int lat);
    bit acc;
    acc = 1'b0;
    lat = -1;
    resp = 'x;
    rd = 'x;
    irq_s = 'x;
    if (wr) begin
      bus.s_axi_awaddr[p*AW +: AW] = a;
      bus.s_axi_wdata[p*32 +: 32] = d;
      bus.s_axi_wstrb[p*4 +: 4] = s;
      bus.s_axi_awvalid[p] = 1'b1;
      bus.s_axi_wvalid[p] = 1'b1;
    end else begin
      bus.s_axi_araddr[p*AW +: AW] = a;
      bus.s_axi_arvalid[p] = 1'b1;
    end
    for (int c = 0; c < 16 && !acc; c++) begin
      @(negedge ACLK);
      acc = wr ? (bus.s_axi_awready[p] && bus.s_axi_wready[p])
               : bus.s_axi_arready[p];
      @(posedge ACLK);
      #1;
    end
    bus.s_axi_awvalid[p] = 1'b0;
    bus.s_axi_wvalid[p] = 1'b0;
    bus.s_axi_arvalid[p] = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout port=%0d actual=0 required=1", p);
      return;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge ACLK);
      if (wr ? bus.s_axi_bvalid[p] : bus.s_axi_rvalid[p]) begin
        lat = c + 1;
        resp = wr ? bus.s_axi_bresp[p*2 +: 2] : bus.s_axi_rresp[p*2 +: 2];
        rd = bus.s_axi_rdata[p*32 +: 32];
        irq_s = irq;
        if (wr) bus.s_axi_bready[p] = 1'b1;
        else bus.s_axi_rready[p] = 1'b1;
        @(posedge ACLK);
        #1;
        bus.s_axi_bready[p] = 1'b0;
        bus.s_axi_rready[p] = 1'b0;
        break;
      end
    end
    if (lat < 0) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  logic [1:0] resp, irq_s;
  logic [31:0] rd;
  int lat;

  initial begin
    bus.s_axi_awaddr = '0;
    bus.s_axi_awprot = '0;
    bus.s_axi_awvalid = '0;
    bus.s_axi_wdata = '0;
    bus.s_axi_wstrb = '0;
    bus.s_axi_wvalid = '0;
    bus.s_axi_bready = '0;
    bus.s_axi_araddr = '0;
    bus.s_axi_arprot = '0;
    bus.s_axi_arvalid = '0;
    bus.s_axi_rready = '0;

    vt.push_back(R(0, 12'h000, ID, 2'b00, 1'b1, 2'b00));
    vt.push_back(R(0, 12'h004, 32'h0, 2'b00, 1'b0, 2'b00));
    vt.push_back(W(0, 12'h004, 32'h1, 4'hF, 2'b00, 1'b0, 2'b00));
    vt.push_back(W(0, 12'h008, 32'h2, 4'hF, 2'b00, 1'b0, 2'b00));
    vt.push_back(W(0, 12'h00C, 32'h3, 4'hF, 2'b00, 1'b0, 2'b00));
    vt.push_back(W(0, 12'h010, 32'h4, 4'hF, 2'b00, 1'b0, 2'b00));
    vt.push_back(R(1, 12'h004, 32'h1, 2'b00, 1'b0, 2'b00));
    vt.push_back(R(1, 12'h008, 32'h2, 2'b00, 1'b0, 2'b00));
    vt.push_back(R(1, 12'h00C, 32'h3, 2'b00, 1'b0, 2'b00));
    vt.push_back(R(1, 12'h010, 32'h4, 2'b00, 1'b0, 2'b00));
    vt.push_back(W(0, 12'h014, 32'hAABBCCDD, 4'hF, 2'b00, 1'b0, 2'b00));
    vt.push_back(W(0, 12'h014, 32'h00001100, 4'h2, 2'b00, 1'b0, 2'b00));
    vt.push_back(R(1, 12'h014, 32'hAABB11DD, 2'b00, 1'b0, 2'b00));
    vt.push_back(W(1, 12'h03C, 32'h1, 4'hF, 2'b00, 1'b1, 2'b01));
    vt.push_back(R(0, 12'h03C, 32'h1, 2'b00, 1'b1, 2'b01));
    vt.push_back(W(0, 12'h038, 32'h1, 4'hF, 2'b00, 1'b1, 2'b00));
    vt.push_back(R(0, 12'h038, 32'h0, 2'b00, 1'b0, 2'b00));
    vt.push_back(W(0, 12'h03C, 32'h3, 4'h0, 2'b00, 1'b1, 2'b00));
    vt.push_back(W(0, 12'h03C, 32'h2, 4'h1, 2'b00, 1'b1, 2'b10));
    vt.push_back(R(1, 12'h03C, 32'h2, 2'b00, 1'b1, 2'b10));
    vt.push_back(W(1, 12'h038, 32'hFFFFFFFF, 4'hF, 2'b00, 1'b1, 2'b00));
    vt.push_back(R(0, 12'h040, 32'h0, 2'b10, 1'b0, 2'b00));
    vt.push_back(W(0, 12'h000, 32'hFFFFFFFF, 4'hF, 2'b00, 1'b0, 2'b00));
    vt.push_back(R(0, 12'h000, ID, 2'b00, 1'b0, 2'b00));
    vt.push_back(W(1, 12'h040, 32'hDEADBEEF, 4'hF, 2'b10, 1'b0, 2'b00));
    vt.push_back(R(1, 12'h007, 32'h1, 2'b00, 1'b0, 2'b00));
    vt.push_back(R(0, 12'hFFC, 32'h0, 2'b10, 1'b0, 2'b00));

    // Reset state, with a read request held during reset.
    bus.s_axi_arvalid[0] = 1'b1;
    @(negedge ACLK);
    chk("rst_arready", 32'(bus.s_axi_arready), 32'h0);
    chk("rst_bvalid", 32'(bus.s_axi_bvalid), 32'h0);
    chk("rst_rvalid", 32'(bus.s_axi_rvalid), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", bus.s_axi_rdata[31:0], 32'h0);
    bus.s_axi_arvalid[0] = 1'b0;
    do_reset();
    @(negedge ACLK);
    chk("post_rst_awready", 32'(bus.s_axi_awready), 32'h0);
    chk("post_rst_bresp", 32'(bus.s_axi_bresp), 32'h0);
    @(posedge ACLK);
    #1;

    foreach (vt[i]) begin
      txn(vt[i].port, vt[i].wr, vt[i].addr, vt[i].data, vt[i].strb,
          resp, rd, irq_s, lat);
      chk($sformatf("v%0d_resp", i), 32'(resp), 32'(vt[i].exp_resp));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd1);
      if (!vt[i].wr)
        chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
      if (vt[i].chk_irq)
        chk($sformatf("v%0d_irq", i), 32'(irq_s), 32'(vt[i].exp_irq));
    end

    // Two ports write reg 6 in the same cycle with pointer at 0.
    do_reset();
    bus.s_axi_awaddr = {12'h018, 12'h018};
    bus.s_axi_wdata = {32'h22, 32'h11};
    bus.s_axi_wstrb = 8'hFF;
    bus.s_axi_awvalid = 2'b11;
    bus.s_axi_wvalid = 2'b11;
    @(negedge ACLK);
    chk("cc_awready0", 32'(bus.s_axi_awready), 32'h1);
    chk("cc_wready0", 32'(bus.s_axi_wready), 32'h1);
    @(posedge ACLK);
    #1;
    bus.s_axi_awvalid[0] = 1'b0;
    bus.s_axi_wvalid[0] = 1'b0;
    @(negedge ACLK);
    chk("cc_awready1", 32'(bus.s_axi_awready), 32'h2);
    chk("cc_bvalid0", 32'(bus.s_axi_bvalid), 32'h1);
    bus.s_axi_bready = 2'b11;
    @(posedge ACLK);
    #1;
    bus.s_axi_awvalid[1] = 1'b0;
    bus.s_axi_wvalid[1] = 1'b0;
    @(negedge ACLK);
    chk("cc_bvalid1", 32'(bus.s_axi_bvalid), 32'h2);
    @(posedge ACLK);
    #1;
    bus.s_axi_bready = 2'b00;
    bus.s_axi_araddr = {12'h018, 12'h018};
    bus.s_axi_arvalid = 2'b11;
    @(negedge ACLK);
    chk("cc_ptr0", 32'(bus.s_axi_arready), 32'h1);
    @(posedge ACLK);
    #1;
    bus.s_axi_arvalid[0] = 1'b0;
    @(negedge ACLK);
    chk("cc_arready1", 32'(bus.s_axi_arready), 32'h2);
    chk("cc_rvalid0", 32'(bus.s_axi_rvalid), 32'h1);
    chk("cc_rdata0", bus.s_axi_rdata[31:0], 32'h22);
    bus.s_axi_rready = 2'b11;
    @(posedge ACLK);
    #1;
    bus.s_axi_arvalid[1] = 1'b0;
    @(negedge ACLK);
    chk("cc_rvalid1", 32'(bus.s_axi_rvalid), 32'h2);
    chk("cc_rdata1", bus.s_axi_rdata[63:32], 32'h22);
    @(posedge ACLK);
    #1;
    bus.s_axi_rready = 2'b00;

    // Reset while a write response is pending.
    bus.s_axi_awaddr[11:0] = 12'h004;
    bus.s_axi_wdata[31:0] = 32'h5A;
    bus.s_axi_wstrb[3:0] = 4'hF;
    bus.s_axi_awvalid[0] = 1'b1;
    bus.s_axi_wvalid[0] = 1'b1;
    @(negedge ACLK);
    chk("rb_accept", 32'(bus.s_axi_awready[0]), 32'h1);
    @(posedge ACLK);
    #1;
    bus.s_axi_awvalid[0] = 1'b0;
    bus.s_axi_wvalid[0] = 1'b0;
    @(negedge ACLK);
    chk("rb_bvalid_before", 32'(bus.s_axi_bvalid), 32'h1);
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rb_bvalid_dropped", 32'(bus.s_axi_bvalid), 32'h0);
    repeat (3) @(negedge ACLK);
    chk("rb_no_replay", 32'(bus.s_axi_bvalid), 32'h0);
    @(posedge ACLK);
    #1;
    txn(0, 1'b0, 12'h004, 32'h0, 4'h0, resp, rd, irq_s, lat);
    chk("rb_reg1_cleared", rd, 32'h0);
    chk("rb_read_resp", 32'(resp), 32'h0);
    chk("rb_irq", 32'(irq_s), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
